// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, IDLE/SETUP/ACCESS sequencing,
// slave-select decode from the top address bits and a PREADY timeout. All outputs registered.
module apb_master_arb #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int TOUT   = 15
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [1:0]          req,
  input  logic [1:0]          wr,
  input  logic [2*AWIDTH-1:0] addr,
  input  logic [2*DWIDTH-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                err,
  output logic [DWIDTH-1:0]   rdata,
  output logic [3:0]          PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [AWIDTH-1:0]   PADDR,
  output logic [DWIDTH-1:0]   PWDATA,
  input  logic [DWIDTH-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(TOUT - 1);

  logic [1:0]        state_reg, state_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic [1:0]        done_reg, done_next;
  logic              err_reg, err_next;
  logic [DWIDTH-1:0] rdata_reg, rdata_next;
  logic [3:0]        psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [AWIDTH-1:0] paddr_reg, paddr_next;
  logic [DWIDTH-1:0] pwdata_reg, pwdata_next;
  logic [7:0]        wait_cnt_reg, wait_cnt_next;
  logic              last_reg, last_next;

  logic [AWIDTH-1:0] req_addr  [2];
  logic [DWIDTH-1:0] req_wdata [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_addr[gi]  = addr[gi*AWIDTH +: AWIDTH];
      assign req_wdata[gi] = wdata[gi*DWIDTH +: DWIDTH];
    end
  endgenerate

  // A requester whose done is high this cycle is not eligible, so it can drop req in time.
  logic [1:0] eligible;
  logic       win;
  logic [1:0] win_sel;
  assign eligible = req & ~done_reg;
  assign win      = (&eligible) ? ~last_reg : eligible[1];
  assign win_sel  = req_addr[win][AWIDTH-1 -: 2];

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    done_next     = 2'b00;
    err_next      = 1'b0;
    rdata_next    = '0;
    psel_next     = psel_reg;
    penable_next  = penable_reg;
    pwrite_next   = pwrite_reg;
    paddr_next    = paddr_reg;
    pwdata_next   = pwdata_reg;
    wait_cnt_next = wait_cnt_reg;
    last_next     = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|eligible) begin
          state_next  = ST_SETUP;
          gnt_next    = win ? 2'b10 : 2'b01;
          last_next   = win;
          pwrite_next = wr[win];
          paddr_next  = req_addr[win];
          pwdata_next = req_wdata[win];
          psel_next   = 4'b0001 << win_sel;
        end
      end
      ST_SETUP: begin
        state_next   = ST_ACCESS;
        penable_next = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY || wait_cnt_reg == WAIT_LAST) begin
          state_next    = ST_IDLE;
          psel_next     = 4'b0000;
          penable_next  = 1'b0;
          gnt_next      = 2'b00;
          done_next     = gnt_reg;
          wait_cnt_next = 8'd0;
          // PREADY takes priority, so a response in the last allowed cycle still completes.
          if (PREADY) begin
            err_next   = PSLVERR;
            rdata_next = (pwrite_reg || PSLVERR) ? '0 : PRDATA;
          end else begin
            err_next   = 1'b1;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= 2'b00;
      done_reg     <= 2'b00;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      psel_reg     <= 4'b0000;
      penable_reg  <= 1'b0;
      pwrite_reg   <= 1'b0;
      paddr_reg    <= '0;
      pwdata_reg   <= '0;
      wait_cnt_reg <= 8'd0;
      last_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      rdata_reg    <= rdata_next;
      psel_reg     <= psel_next;
      penable_reg  <= penable_next;
      pwrite_reg   <= pwrite_next;
      paddr_reg    <= paddr_next;
      pwdata_reg   <= pwdata_next;
      wait_cnt_reg <= wait_cnt_next;
      last_reg     <= last_next;
    end
  end

  assign gnt     = gnt_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign rdata   = rdata_reg;
  assign PSEL    = psel_reg;
  assign PENABLE = penable_reg;
  assign PWRITE  = pwrite_reg;
  assign PADDR   = paddr_reg;
  assign PWDATA  = pwdata_reg;
endmodule

// File: tb/tb_apb_master_arb.sv
// Randomized scoreboard bench for apb_master_arb: a transaction-level model predicts grant
// order and completion results; a slave model and a done monitor check the bus independently.
module tb_apb_master_arb;
  localparam int TOUT = 15;

  logic       PCLK, PRESET;
  logic [1:0] req, wr;
  logic [7:0] addr;
  logic [15:0] wdata;
  logic [1:0] gnt, done;
  logic       err;
  logic [7:0] rdata;
  logic [3:0] PSEL;
  logic       PENABLE, PWRITE;
  logic [3:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;

  apb_master_arb #(.DWIDTH(8), .AWIDTH(4), .TOUT(TOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  typedef struct {
    int         owner;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    logic       pslverr;
    int         waitc;
    logic       abort;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_len;
  } txn_t;

  txn_t exp_q[$];
  txn_t slv_q[$];
  txn_t drv_q0[$];
  txn_t drv_q1[$];
  int   checks = 0;
  int   failures = 0;
  int   model_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected results follow directly from the transfer rules: a slave that waits
  // TOUT or more cycles is aborted after TOUT ACCESS cycles with err=1.
  function automatic txn_t make_txn(input int owner, input logic w, input logic [3:0] a,
                                    input logic [7:0] wd, input logic [7:0] rd,
                                    input logic se, input int waitc);
    txn_t t;
    t.owner = owner; t.wr = w; t.addr = a; t.wdata = wd; t.prdata = rd;
    t.pslverr = se; t.waitc = waitc; t.abort = 1'b0;
    t.exp_len   = (waitc >= TOUT) ? TOUT : waitc + 1;
    t.exp_err   = (waitc >= TOUT) || se;
    t.exp_rdata = (w || t.exp_err) ? 8'h00 : rd;
    return t;
  endfunction

  task automatic add_txn(input int owner, input logic w, input logic [3:0] a,
                         input logic [7:0] wd, input logic [7:0] rd, input logic se,
                         input int waitc);
    if (owner == 0) drv_q0.push_back(make_txn(owner, w, a, wd, rd, se, waitc));
    else            drv_q1.push_back(make_txn(owner, w, a, wd, rd, se, waitc));
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r < 8) return TOUT - 1 + int'($urandom_range(0, 1));
    return TOUT + int'($urandom_range(1, 6));
  endfunction

  task automatic add_rand(input int owner);
    add_txn(owner, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 4) == 0), rand_wait());
  endtask

  // Requester i presents its transactions one by one, dropping req in the done cycle.
  task automatic drive(input int i, input bit single);
    txn_t t;
    int   cyc;
    int   k;
    k = 0;
    while ((i == 0 ? drv_q0.size() : drv_q1.size()) > 0) begin
      if (i == 0) t = drv_q0.pop_front();
      else        t = drv_q1.pop_front();
      wr[i] = t.wr;
      addr[i*4 +: 4] = t.addr;
      wdata[i*8 +: 8] = t.wdata;
      req[i] = 1'b1;
      cyc = 0;
      do begin
        @(negedge PCLK);
        cyc++;
      end while (!done[i] && cyc < 200);
      if (!done[i]) begin
        checks++;
        failures++;
        $display("FAIL req%0d_done_timeout actual=none required=done within 200 cycles", i);
        req[i] = 1'b0;
        return;
      end
      if (single && k == 0) chk("latency", 32'(cyc), 32'(2 + t.exp_len));
      req[i] = 1'b0;
      k++;
      @(negedge PCLK);
    end
  endtask

  // Round-robin at transaction level: while both have work they alternate, starting
  // with the one that did not win last; then the remaining requester runs alone.
  task automatic run_round();
    txn_t a[$];
    txn_t b[$];
    txn_t t;
    bit   single;
    int   pick;
    a = drv_q0;
    b = drv_q1;
    single = (a.size() == 0) || (b.size() == 0);
    while (a.size() + b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) pick = (model_last == 0) ? 1 : 0;
      else pick = (a.size() > 0) ? 0 : 1;
      if (pick == 0) t = a.pop_front();
      else           t = b.pop_front();
      exp_q.push_back(t);
      slv_q.push_back(t);
      model_last = pick;
    end
    fork
      drive(0, single);
      drive(1, single);
    join
  endtask

  // Slave model: serves transfers in predicted order and checks the bus phase.
  initial begin
    txn_t s;
    int   acnt;
    bit   in_acc;
    int   setup_cnt;
    logic prev_idle;
    in_acc = 0; acnt = 0; setup_cnt = 0; prev_idle = 1'b1;
    s = make_txn(0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 0);
    forever begin
      @(negedge PCLK);
      if (PSEL != 4'b0000 && PENABLE) begin
        if (!in_acc) begin
          in_acc = 1;
          acnt = 0;
          if (slv_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL access_unexpected actual=PSEL %b required=no transfer", PSEL);
            s = make_txn(0, PWRITE, PADDR, 8'h00, 8'h00, 1'b0, 0);
          end else begin
            s = slv_q.pop_front();
          end
          chk("setup_cycles", 32'(setup_cnt), 32'd1);
          chk("psel", 32'(PSEL), 32'(4'b0001 << s.addr[3:2]));
          chk("paddr", 32'(PADDR), 32'(s.addr));
          chk("pwrite", 32'(PWRITE), 32'(s.wr));
          chk("gnt", 32'(gnt), 32'(2'b01 << s.owner));
          if (s.wr) chk("pwdata", 32'(PWDATA), 32'(s.wdata));
        end
        acnt++;
        PREADY  = (acnt > s.waitc);
        PRDATA  = s.prdata;
        PSLVERR = s.pslverr;
      end else begin
        if (in_acc) begin
          in_acc = 0;
          if (!s.abort) chk("access_len", 32'(acnt), 32'(s.exp_len));
        end
        if (PSEL != 4'b0000) begin
          if (setup_cnt == 0) chk("idle_gap", 32'(prev_idle), 32'd1);
          setup_cnt++;
        end else begin
          setup_cnt = 0;
        end
        // Outside ACCESS the slave lines carry noise that the master must ignore.
        PREADY  = 1'($urandom_range(0, 1));
        PRDATA  = 8'($urandom);
        PSLVERR = 1'($urandom_range(0, 1));
      end
      prev_idle = (PSEL == 4'b0000);
    end
  end

  // Completion monitor: pops one expected result per done pulse.
  initial begin
    txn_t m;
    forever begin
      @(negedge PCLK);
      if (!PRESET && done !== 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=%b required=00", done);
        end else begin
          m = exp_q.pop_front();
          chk("done_owner", 32'(done), 32'(2'b01 << m.owner));
          chk("err", 32'(err), 32'(m.exp_err));
          chk("rdata", 32'(rdata), 32'(m.exp_rdata));
          chk("psel_in_done", 32'(PSEL), 32'd0);
          $display("txn owner=%0d wr=%0d addr=%h wdata=%h wait=%0d err=%0d rdata=%h",
                   m.owner, m.wr, m.addr, m.wdata, m.waitc, err, rdata);
        end
      end
    end
  end

  initial begin
    txn_t t;
    int   cyc;
    PRESET = 1'b1; req = 2'b00; wr = 2'b00; addr = 8'h00; wdata = 16'h0000;
    PRDATA = 8'h00; PREADY = 1'b0; PSLVERR = 1'b0;
    model_last = 1;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", 32'(PWDATA), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    add_txn(0, 1'b1, 4'h5, 8'hA5, 8'h00, 1'b0, 0);
    run_round();
    add_txn(1, 1'b0, 4'hC, 8'h00, 8'h3C, 1'b0, 2);
    run_round();
    for (int k = 0; k < 2; k++) begin
      add_txn(0, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
      add_txn(1, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
    end
    run_round();
    add_txn(0, 1'b0, 4'h2, 8'h00, 8'h77, 1'b0, TOUT + 5);
    run_round();
    add_txn(1, 1'b0, 4'h9, 8'h00, 8'hFF, 1'b1, 0);
    run_round();

    for (int r = 0; r < 40; r++) begin
      int pat;
      pat = int'($urandom_range(0, 2));
      if (pat != 1) for (int k = int'($urandom_range(1, 3)); k > 0; k--) add_rand(0);
      if (pat != 0) for (int k = int'($urandom_range(1, 3)); k > 0; k--) add_rand(1);
      run_round();
    end

    // Reset during ACCESS: the transfer is discarded and no done may follow.
    t = make_txn(0, 1'b0, 4'h8, 8'h00, 8'h11, 1'b0, 40);
    t.abort = 1'b1;
    slv_q.push_back(t);
    wr[0] = 1'b0; addr[3:0] = 4'h8; req[0] = 1'b1;
    cyc = 0;
    do begin
      @(negedge PCLK);
      cyc++;
    end while (!PENABLE && cyc < 20);
    chk("reset_test_reached_access", 32'(PENABLE), 32'd1);
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    req = 2'b00;
    chk("midrst_psel", 32'(PSEL), 32'd0);
    chk("midrst_penable", 32'(PENABLE), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (3) @(negedge PCLK);
    model_last = 1;
    add_txn(0, 1'b1, 4'h1, 8'h5A, 8'h00, 1'b0, 1);
    add_txn(1, 1'b0, 4'hE, 8'h00, 8'hC3, 1'b0, 0);
    run_round();

    repeat (5) @(negedge PCLK);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("slv_q_drained", 32'(slv_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-requester APB master that sequences every transfer on the shared peripheral bus feeding the register slaves. Arbitrates round-robin between two command ports, runs the IDLE/SETUP/ACCESS protocol, decodes one of four slave selects from the address, and returns read data, completion and error per requester. A timeout counter aborts transfers whose slave never asserts PREADY.

## Interface
Parameters:
- DWIDTH, 8, data width of PWDATA/PRDATA and requester data
- AWIDTH, 4, address width; top 2 bits select the slave
- TOUT, 15, maximum ACCESS cycles with PREADY low before abort (1..255)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous active-high reset
- req  in  2  per-requester request, level; held until that requester's done
- wr  in  2  per-requester direction, 1 = write
- addr  in  2*AWIDTH  requester 0 in [AWIDTH-1:0], requester 1 above
- wdata  in  2*DWIDTH  same packing as addr
- gnt  out  2  one-hot, high SETUP through ACCESS of the owning transfer
- done  out  2  one-cycle completion pulse to the owner
- err  out  1  valid with done; 1 = PSLVERR or timeout
- rdata  out  DWIDTH  read data, valid with done; 0 for writes and errors
- PSEL  out  4  one-hot slave select, index = PADDR[AWIDTH-1:AWIDTH-2]
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  AWIDTH  APB address
- PWDATA  out  DWIDTH  APB write data
- PRDATA  in  DWIDTH  read data from selected slave
- PREADY  in  1  slave ready; zero-wait slaves tie to 1
- PSLVERR  in  1  slave error, sampled with PREADY

## Operation
- All outputs registered. FSM states: IDLE, SETUP, ACCESS.
- IDLE: PSEL=0, PENABLE=0. Eligible request = req[i] & ~done[i]. If any eligible: pick winner, latch its wr/addr/wdata into PWRITE/PADDR/PWDATA, set gnt, go SETUP. Otherwise stay.
- Arbitration: pointer `last` holds last winner. One eligible -> it wins. Both -> winner = ~last. `last` updates on each grant.
- SETUP: PSEL[decoded]=1, PENABLE=0, exactly one cycle -> ACCESS.
- ACCESS: PSEL held, PENABLE=1, address/data/direction stable. Wait counter increments each cycle with PREADY=0.
  - PREADY=1: capture PRDATA (reads only) and PSLVERR -> IDLE; next cycle done[owner]=1, err=PSLVERR, rdata=captured data (0 if write or PSLVERR).
  - Counter reaches TOUT with PREADY still 0: abort -> IDLE; next cycle done[owner]=1, err=1, rdata=0.
- Leaving ACCESS: PSEL, PENABLE, gnt to 0; PADDR/PWDATA/PWRITE hold last value; wait counter cleared.
- Requester inputs are ignored outside IDLE; changing them mid-transfer has no effect.
- No back-to-back transfers: PSEL always low for at least the done cycle.

## Timing
- Reset: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, gnt=0, done=0, err=0, rdata=0, counter=0, last=1 (requester 0 wins first tie).
- Zero-wait transfer: req sampled end of cycle 0; cycle 1 SETUP; cycle 2 ACCESS; cycle 3 done/IDLE; next grant sampled end of cycle 3, SETUP in cycle 4. Throughput one transfer per 3 cycles.
- Each PREADY-low cycle adds one ACCESS cycle. Timeout: ACCESS lasts exactly TOUT cycles, done on the following cycle.
- Requester must drop req on the cycle done is high or will be re-granted; done[i] masks req[i] that cycle only.
- PRESET mid-transfer: next cycle all outputs at reset values, no done issued, transfer discarded.
- PREADY/PSLVERR ignored outside ACCESS.

## Test plan
- Reset then single write, req0 addr=4'h5 wdata=8'hA5, PREADY=1 -> cycle 1 PSEL=4'b0010 PENABLE=0 PWRITE=1, cycle 2 PENABLE=1, cycle 3 done=2'b01 err=0 rdata=0.
- Read req1 addr=4'hC, PRDATA=8'h3C, PREADY low 2 cycles -> ACCESS 3 cycles, PSEL=4'b1000, done=2'b10 rdata=8'h3C err=0.
- Both req held for 4 transfers -> grants 0,1,0,1; PSEL low one cycle between each; transfer start every 3 cycles.
- PREADY stuck 0, TOUT=15 -> PENABLE high exactly 15 cycles, then done err=1 rdata=0, bus idle.
- PSLVERR=1 with PREADY on read, PRDATA=8'hFF -> err=1, rdata=0.
- PRESET asserted during ACCESS -> next cycle PSEL=0 PENABLE=0 gnt=0, no done; next tie grants requester 0.
